// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and default sizes for the serial pattern scan controller.
// Holds the FSM state encoding and the default width constants.
package seq_scan_ctrl_pkg;

  localparam int MAX_LEN_D = 8;
  localparam int LEN_W_D   = 4;
  localparam int WIN_W_D   = 10;
  localparam int CNT_W_D   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_scan_ctrl_match.sv
// Pattern match core: history shift register, fill count, masked compare.
// Ports: clock/reset, clr_i, accept_i, bit_i, pattern/len/overlap, match_o.
module seq_match_core
  import seq_scan_ctrl_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_D,
  parameter int LEN_W   = LEN_W_D
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               accept_i,
  input  logic               bit_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic               match_o
);

  // Oldest bit falls out of the shift; only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W:0]     fill_inc;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_i));
    end
  end

  assign hist_nxt = {hist_q, bit_i};
  assign fill_inc = {1'b0, fill_q} + 1'b1;

  assign match_o = accept_i
                && (fill_inc >= {1'b0, len_i})
                && (((hist_nxt ^ pattern_i) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (accept_i) begin
      hist_d = hist_nxt[MAX_LEN-2:0];
      if (match_o && !overlap_i) begin
        fill_d = '0;
      end else if (fill_inc >= {1'b0, len_i}) begin
        fill_d = len_i;
      end else begin
        fill_d = fill_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: latches config, sequences a bounded window of bits.
// Ports: cfg_*, start/abort, bit_valid/bit_in/bit_ready, status outputs.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_D,
  parameter int LEN_W   = LEN_W_D,
  parameter int WIN_W   = WIN_W_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               busy,
  output logic               err_cfg,
  output logic               match_pulse,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic [WIN_W-1:0]   first_pos,
  output logic               first_valid
);

  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIN_W-1:0]   fpos_q;
  logic               fvalid_q;
  logic               busy_q;
  logic               err_q;
  logic               mp_q;
  logic               done_q;

  logic cfg_ok;
  logic launch;
  logic accept;
  logic match;

  assign cfg_ok = (cfg_len != '0)
               && (int'(cfg_len) <= MAX_LEN)
               && (cfg_window != '0);

  assign launch    = (state_q == ST_IDLE) && start && cfg_ok;
  assign bit_ready = (state_q == ST_SCAN) && !abort;
  assign accept    = bit_valid && bit_ready;

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (launch),
    .accept_i  (accept),
    .bit_i     (bit_in),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .overlap_i (ovl_q),
    .match_o   (match)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      win_q     <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      fpos_q    <= '0;
      fvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mp_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      mp_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            win_q <= cfg_window;
            if (!cfg_ok) begin
              err_q <= 1'b1;
            end else begin
              bit_cnt_q <= '0;
              cnt_q     <= '0;
              fpos_q    <= '0;
              fvalid_q  <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (accept) begin
            bit_cnt_q <= bit_cnt_q + WIN_W'(1);
            if (match) begin
              mp_q <= 1'b1;
              if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
              if (!fvalid_q) begin
                fpos_q   <= bit_cnt_q;
                fvalid_q <= 1'b1;
              end
            end
            // Last bit of the window: done lines up with its match pulse.
            if (bit_cnt_q == win_q - WIN_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign err_cfg     = err_q;
  assign match_pulse = mp_q;
  assign done        = done_q;
  assign match_count = cnt_q;
  assign first_pos   = fpos_q;
  assign first_valid = fvalid_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized + directed bench for seq_scan_ctrl.
// Reference model tracks accepted bits as an array and scans it directly.
module tb_seq_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [9:0] cfg_window;
  logic       start, abort, bit_valid, bit_in;
  logic       bit_ready, busy, err_cfg;
  logic       match_pulse, done, first_valid;
  logic [7:0] match_count;
  logic [9:0] first_pos;

  seq_scan_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_window  (cfg_window),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .bit_ready   (bit_ready),
    .busy        (busy),
    .err_cfg     (err_cfg),
    .match_pulse (match_pulse),
    .done        (done),
    .match_count (match_count),
    .first_pos   (first_pos),
    .first_valid (first_valid)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: 0 idle, 1 scanning, 2 finishing.
  int       m_st;
  int       m_cnt, m_fpos, m_idx, m_since;
  bit       m_fv, m_mp, m_done, m_err;
  bit [7:0] s_pat;
  int       s_len, s_win;
  bit       s_ovl;
  bit       m_bits [1024];

  // Match if the last s_len bits since the last clear equal the pattern.
  function automatic bit is_match(int k);
    if (k - m_since + 1 < s_len) return 1'b0;
    for (int j = 0; j < s_len; j++) begin
      if (m_bits[k-j] != s_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear;
    m_st = 0; m_cnt = 0; m_fpos = 0; m_fv = 0;
    m_mp = 0; m_done = 0; m_err = 0;
    m_idx = 0; m_since = 0;
  endtask

  task automatic check_outs;
    chk("busy", busy, (m_st != 0));
    chk("err_cfg", err_cfg, m_err);
    chk("match_pulse", match_pulse, m_mp);
    chk("done", done, m_done);
    chk("match_count", match_count, m_cnt);
    chk("first_pos", first_pos, m_fpos);
    chk("first_valid", first_valid, m_fv);
  endtask

  // One clock: drive after a falling edge, predict, check at next fall.
  task automatic cyc(bit st, bit ab, bit v, bit b);
    start = st; abort = ab; bit_valid = v; bit_in = b;
    #1;
    chk("bit_ready", bit_ready, (m_st == 1 && !ab));
    m_mp = 0; m_done = 0; m_err = 0;
    case (m_st)
      0: if (st) begin
        if (cfg_len == 0 || cfg_len > 8 || cfg_window == 0) begin
          m_err = 1;
        end else begin
          s_pat = cfg_pattern; s_len = cfg_len;
          s_ovl = cfg_overlap; s_win = cfg_window;
          m_cnt = 0; m_fpos = 0; m_fv = 0;
          m_idx = 0; m_since = 0; m_st = 1;
        end
      end
      1: if (ab) begin
        m_st = 0;
      end else if (v) begin
        m_bits[m_idx] = b;
        if (is_match(m_idx)) begin
          m_mp = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_fv) begin m_fpos = m_idx; m_fv = 1; end
          if (!s_ovl) m_since = m_idx + 1;
        end
        if (m_idx == s_win - 1) begin m_st = 2; m_done = 1; end
        m_idx++;
      end
      default: m_st = 0;
    endcase
    @(negedge clock);
    check_outs();
  endtask

  task automatic do_reset;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_err", err_cfg, 0);
    chk("rst_mp", match_pulse, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", match_count, 0);
    chk("rst_fpos", first_pos, 0);
    chk("rst_fv", first_valid, 0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_cfg(bit [7:0] p, int l, bit o, int w);
    cfg_pattern = p; cfg_len = 4'(l);
    cfg_overlap = o; cfg_window = 10'(w);
  endtask

  // Start then feed nb bits MSB-first, optional idle gap before each.
  task automatic run_stream(bit [63:0] s, int nb, bit gaps);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < nb; i++) begin
      if (gaps) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, s[nb-1-i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 0; abort = 0; bit_valid = 0; bit_in = 0;
    set_cfg(8'h00, 0, 0, 0);
    model_clear();
    @(negedge clock);
    @(negedge clock);
    check_outs();
    reset = 1'b0;
    @(negedge clock);

    // 10011 overlapping, window 10.
    set_cfg(8'h13, 5, 1, 10);
    run_stream(64'b1001110011, 10, 0);
    chk("t1_done_mp", {done, match_pulse}, 2'b11);
    cyc(0, 0, 0, 0);
    chk("t1_cnt", match_count, 2);
    chk("t1_fpos", first_pos, 4);

    // 11 over 1111, overlap on then off.
    set_cfg(8'h03, 2, 1, 4);
    run_stream(64'b1111, 4, 0);
    cyc(0, 0, 0, 0);
    chk("t2_ovl_cnt", match_count, 3);
    chk("t2_ovl_fpos", first_pos, 1);
    set_cfg(8'h03, 2, 0, 4);
    run_stream(64'b1111, 4, 0);
    cyc(0, 0, 0, 0);
    chk("t2_novl_cnt", match_count, 2);

    // Illegal configs: err pulse only, results kept.
    set_cfg(8'h03, 0, 0, 4);
    cyc(1, 0, 0, 0);
    chk("t3_err_len0", err_cfg, 1);
    set_cfg(8'h03, 2, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3_err_gone", err_cfg, 0);
    cyc(1, 0, 0, 0);
    chk("t3_err_win0", err_cfg, 1);
    set_cfg(8'h03, 9, 0, 4);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3_keep_cnt", match_count, 2);

    // Window 6 with valid gaps.
    set_cfg(8'h05, 3, 1, 6);
    run_stream(64'b101101, 6, 1);
    cyc(0, 0, 0, 0);

    // Abort after 3 bits, then restart.
    set_cfg(8'h01, 1, 1, 10);
    run_stream(64'b101, 3, 0);
    cyc(0, 1, 1, 1);
    chk("t5_busy_drop", busy, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
    set_cfg(8'h01, 1, 1, 3);
    run_stream(64'b110, 3, 0);
    cyc(0, 0, 0, 0);
    chk("t5_restart_cnt", match_count, 2);

    // Reset mid-scan after a match.
    set_cfg(8'h03, 2, 1, 10);
    run_stream(64'b111, 3, 0);
    do_reset();
    set_cfg(8'h03, 2, 1, 4);
    run_stream(64'b1011, 4, 0);
    cyc(0, 0, 0, 0);
    chk("t6_cnt", match_count, 1);

    // Randomized scans.
    for (int it = 0; it < 300; it++) begin
      int l, w, guard;
      l = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15)
                                       : $urandom_range(1, 4);
      w = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 30);
      set_cfg(8'($urandom), l, 1'($urandom), w);
      cyc(1, 0, 0, 0);
      guard = 0;
      while (m_st != 0 && guard < 200) begin
        set_cfg(8'($urandom), $urandom_range(0, 15),
                1'($urandom), $urandom_range(0, 1023));
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end else begin
          cyc($urandom_range(0, 9) == 0,
              $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0,
              1'($urandom));
        end
        guard++;
      end
      chk("rand_scan_bounded", (guard < 200), 1);
      cyc(0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Controller that configures and sequences a programmable serial pattern detector over a bounded scan window.
- Software-facing side: configuration bus plus start/abort; stream side: valid/ready serial bit input.
- Reports per-match pulses, match count, first-match position and completion; sits between the CSR block and the serial bit source.

Parameters:
MAX_LEN, 8, maximum pattern length in bits.
LEN_W, 4, width of cfg_len; must hold MAX_LEN.
WIN_W, 10, width of window length and bit-position counters.
CNT_W, 8, width of match counter.

Ports:
clock  in  1  system clock.
reset  in  1  async reset.
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last.
cfg_len  in  LEN_W  pattern length, valid range 1..MAX_LEN.
cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
cfg_window  in  WIN_W  number of bits to scan, valid range 1..2^WIN_W-1.
start  in  1  begin scan; sampled in IDLE only.
abort  in  1  terminate scan; no done.
bit_valid  in  1  serial bit present.
bit_in  in  1  serial data bit.
bit_ready  out  1  controller accepts bit this cycle.
busy  out  1  state != IDLE.
err_cfg  out  1  one-cycle pulse: start rejected due to illegal config.
match_pulse  out  1  one-cycle pulse per match.
done  out  1  one-cycle pulse at window completion.
match_count  out  CNT_W  matches in current/last scan, saturating.
first_pos  out  WIN_W  0-based index of the bit completing the first match.
first_valid  out  1  first_pos holds a valid position.

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock (all state on its rising edge).
- Reset: state IDLE; all outputs 0; internal history, fill count, bit counter, latched config cleared.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 latches cfg_* into shadow registers. If cfg_len==0, cfg_len>MAX_LEN or cfg_window==0: err_cfg=1 next cycle, remain IDLE, results untouched. Else clear history, fill, bit counter, match_count, first_pos, first_valid; go SCAN.
- Config inputs ignored outside IDLE start cycle; start ignored when busy.
- bit_ready = (state==SCAN) && !abort, combinational. Accept = bit_valid && bit_ready.
- On accept: hist <= {hist[MAX_LEN-2:0], bit_in}; fill <= min(fill+1, cfg_len); bit counter +1.
- Match on accept when (fill+1) >= cfg_len and low cfg_len bits of new hist == low cfg_len bits of cfg_pattern. Bits above cfg_len ignored.
- On match, registered (1-cycle latency after accept): match_pulse=1, match_count+1 saturating at all-ones. If first_valid==0: first_pos <= bit index, first_valid <= 1. If cfg_overlap==0: fill <= 0.
- Window end: accept of bit index cfg_window-1 moves to DONE; match on that bit pulses in the same cycle as done.
- DONE: done=1 for exactly one cycle, then IDLE. Results hold until next legal start.
- abort in SCAN: go IDLE next cycle, no done, partial results held, same-cycle bit not accepted. abort in IDLE/DONE ignored.
- bit_valid gaps: no state change; counter counts accepted bits only.
- Bit counter does not wrap within a scan (window < 2^WIN_W).
- Reset mid-SCAN: immediate return to reset values.

Decomposition:
- Shared package: state encoding (IDLE/SCAN/DONE), default MAX_LEN/LEN_W/WIN_W/CNT_W constants.
- One sub-module: seq_match_core (history shift register, fill counter, masked compare, overlap clear); controller FSM and counters in top.

Test Plan:
- Pattern 10011 (cfg_pattern=8'h13, len 5, overlap 1, window 10), stream 1001110011 -> match_pulse after bits 4 and 9, match_count=2, first_pos=4, done coincides with second match_pulse.
- Pattern 11 (len 2, window 4), stream 1111: overlap=1 -> count 3, first_pos 1; overlap=0 -> count 2 (positions 1,3).
- cfg_len=0 or cfg_window=0 with start -> err_cfg single pulse, busy stays 0, prior results unchanged.
- Window 6, bit_valid toggling every other cycle -> done only after 6th accepted bit; bit_ready high throughout SCAN.
- Abort after 3 bits of window 10 -> busy drops next cycle, done never asserts, bit not accepted on abort cycle; new start works.
- Assert reset during SCAN after a match -> all outputs 0 immediately; following scan unaffected by prior history.
